// File: rtl/emergency_request_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// emergency_request_conditioner_pkg
// Shared definitions for the emergency request conditioner:
//   - state_t       : arbitration FSM states
//   - DEF_*         : default timing constants
//   - cnt_w_fits()  : checks that a counter width can hold every cycle count
// Optional feature macro used elsewhere in this block: ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
package emergency_request_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_M  = 2'd1,
        ST_GRANT_S  = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    localparam int DEF_DEB_CYCLES = 4;
    localparam int DEF_MIN_HOLD   = 8;
    localparam int DEF_MAX_HOLD   = 200;
    localparam int DEF_COOLDOWN   = 20;
    localparam int DEF_CNT_W      = 8;

    // True when 2^cnt_w exceeds the largest count the counters must reach.
    function automatic bit cnt_w_fits(input int cnt_w, input int deb_cycles,
                                      input int max_hold, input int cooldown);
        longint biggest;
        biggest = deb_cycles;
        if (max_hold > biggest) biggest = max_hold;
        if (cooldown > biggest) biggest = cooldown;
        return (cnt_w > 0) && (cnt_w < 62) && ((longint'(1) << cnt_w) > biggest);
    endfunction

endpackage

// File: rtl/emergency_request_conditioner_if.sv
// -----------------------------------------------------------------------------
// emergency_request_conditioner_if
// Signal bundle between the raw sensors, the conditioner and the light
// controller.
//   Main_Sensor_raw / Side_Sensor_raw : raw asynchronous sensor lines
//   Main_Special / Side_Special       : priority requests (never both 1)
//   Main_Pending / Side_Pending       : debounced request waiting for grant
//   Timeout_Flag                      : one-cycle pulse on forced release
//   state_dbg                         : current arbitration state
// Modports: slave = conditioner side, master = sensor/controller side.
//
// Handshake: there is no valid/ready pair here. A request is a level: the
// grant stays high while the debounced request is high (bounded below by the
// minimum hold and above by the maximum hold); dropping the request is the
// only way to release it early, and the receiver never back-pressures.
// -----------------------------------------------------------------------------
interface emergency_request_conditioner_if;
    import emergency_request_conditioner_pkg::*;

    logic   Main_Sensor_raw;
    logic   Side_Sensor_raw;
    logic   Main_Special;
    logic   Side_Special;
    logic   Main_Pending;
    logic   Side_Pending;
    logic   Timeout_Flag;
    state_t state_dbg;

    modport slave (
        input  Main_Sensor_raw, Side_Sensor_raw,
        output Main_Special, Side_Special, Main_Pending, Side_Pending,
               Timeout_Flag, state_dbg
    );

    modport master (
        output Main_Sensor_raw, Side_Sensor_raw,
        input  Main_Special, Side_Special, Main_Pending, Side_Pending,
               Timeout_Flag, state_dbg
    );

endinterface

// File: rtl/emergency_request_conditioner_sync_debounce.sv
// -----------------------------------------------------------------------------
// emergency_request_conditioner_sync_debounce
// Two-flop synchroniser followed by a debounce counter for one sensor line.
// Ports:
//   Clk, Rst_n : clock, asynchronous active-low reset
//   raw        : raw asynchronous sensor input
//   level      : debounced level
// The level flips on the edge after DEB_CYCLES consecutive synchronised
// samples have disagreed with it; any agreeing sample restarts the count.
// -----------------------------------------------------------------------------
module emergency_request_conditioner_sync_debounce #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic raw,
    output logic level
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] deb_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb_cnt <= '0;
            level   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // A full count of disagreeing samples flips the level on the
            // following edge; the counter never exceeds DEB_CYCLES.
            if (deb_cnt == CNT_W'(DEB_CYCLES)) begin
                level   <= ~level;
                deb_cnt <= '0;
            end else if (sync2 != level) begin
                deb_cnt <= deb_cnt + 1'b1;
            end else begin
                deb_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/emergency_request_conditioner.sv
// -----------------------------------------------------------------------------
// emergency_request_conditioner
// Conditions raw main/side emergency sensors into Main_Special/Side_Special
// priority requests: synchronise + debounce, grant one road at a time with
// minimum and maximum hold, and cool down after a stuck-sensor timeout.
// Ports:
//   Clk   : clock, rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : emergency_request_conditioner_if.slave (sensors in, requests,
//           pending, timeout pulse and state_dbg out)
// Macro ROUND_ROBIN_EN: when defined, simultaneous eligibility goes to the
// road not served most recently; otherwise side always beats main.
// -----------------------------------------------------------------------------
module emergency_request_conditioner
    import emergency_request_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int MIN_HOLD   = DEF_MIN_HOLD,
    parameter int MAX_HOLD   = DEF_MAX_HOLD,
    parameter int COOLDOWN   = DEF_COOLDOWN,
    parameter int CNT_W      = DEF_CNT_W
) (
    input logic                            Clk,
    input logic                            Rst_n,
    emergency_request_conditioner_if.slave bus
);

    if (!cnt_w_fits(CNT_W, DEB_CYCLES, MAX_HOLD, COOLDOWN)) begin : g_cnt_w_check
        $error("CNT_W too narrow for DEB_CYCLES/MAX_HOLD/COOLDOWN");
    end

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COOLDOWN - 1);

    logic             main_deb, side_deb;
    logic             main_armed, side_armed;
    logic             main_elig, side_elig, side_wins;
    logic             main_to, side_to;
    logic             timeout_q;
    logic [CNT_W-1:0] state_cnt;
    state_t           state, state_nxt;

    emergency_request_conditioner_sync_debounce #(
        .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)
    ) u_main_deb (
        .Clk(Clk), .Rst_n(Rst_n), .raw(bus.Main_Sensor_raw), .level(main_deb)
    );

    emergency_request_conditioner_sync_debounce #(
        .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)
    ) u_side_deb (
        .Clk(Clk), .Rst_n(Rst_n), .raw(bus.Side_Sensor_raw), .level(side_deb)
    );

    assign main_elig = main_deb & main_armed;
    assign side_elig = side_deb & side_armed;

`ifdef ROUND_ROBIN_EN
    // 1: main was the last road granted. Reset value lets side win first.
    logic main_last;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            main_last <= 1'b1;
        end else if (state == ST_IDLE && state_nxt == ST_GRANT_M) begin
            main_last <= 1'b1;
        end else if (state == ST_IDLE && state_nxt == ST_GRANT_S) begin
            main_last <= 1'b0;
        end
    end

    assign side_wins = side_elig & (~main_elig | main_last);
`else
    assign side_wins = side_elig;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        main_to   = 1'b0;
        side_to   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (side_wins) begin
                    state_nxt = ST_GRANT_S;
                end else if (main_elig) begin
                    state_nxt = ST_GRANT_M;
                end
            end
            ST_GRANT_M: begin
                // Release takes precedence over timeout on the same edge.
                if (state_cnt >= MIN_LAST && !main_deb) begin
                    state_nxt = ST_IDLE;
                end else if (state_cnt == MAX_LAST) begin
                    state_nxt = ST_COOLDOWN;
                    main_to   = 1'b1;
                end
            end
            ST_GRANT_S: begin
                if (state_cnt >= MIN_LAST && !side_deb) begin
                    state_nxt = ST_IDLE;
                end else if (state_cnt == MAX_LAST) begin
                    state_nxt = ST_COOLDOWN;
                    side_to   = 1'b1;
                end
            end
            ST_COOLDOWN: begin
                if (state_cnt == CD_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // One counter serves both hold and cooldown timing: it restarts on every
    // state change and saturates instead of wrapping.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_cnt <= '0;
        end else if (state_nxt != state) begin
            state_cnt <= '0;
        end else if (state_cnt != '1) begin
            state_cnt <= state_cnt + 1'b1;
        end
    end

    // A timed-out road stays disarmed until its debounced request drops.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            main_armed <= 1'b1;
            side_armed <= 1'b1;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= main_to | side_to;
            if (main_to) begin
                main_armed <= 1'b0;
            end else if (!main_deb) begin
                main_armed <= 1'b1;
            end
            if (side_to) begin
                side_armed <= 1'b0;
            end else if (!side_deb) begin
                side_armed <= 1'b1;
            end
        end
    end

    assign bus.Main_Special = (state == ST_GRANT_M);
    assign bus.Side_Special = (state == ST_GRANT_S);
    assign bus.Main_Pending = main_elig & (state != ST_GRANT_M);
    assign bus.Side_Pending = side_elig & (state != ST_GRANT_S);
    assign bus.Timeout_Flag = timeout_q;
    assign bus.state_dbg    = state;

endmodule

// File: tb/tb_emergency_request_conditioner.sv
// -----------------------------------------------------------------------------
// tb_emergency_request_conditioner
// Directed scenarios plus a randomized run for emergency_request_conditioner.
// Expected output vector {Main_Special, Side_Special, Main_Pending,
// Side_Pending, Timeout_Flag} is produced per edge by a timeline model and
// queued in exp_q; tasks pop and compare on the falling edge.
// Build with +define+ROUND_ROBIN_EN to exercise the round-robin variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_emergency_request_conditioner;
  import emergency_request_conditioner_pkg::*;

  localparam int DEB  = 4;
  localparam int MINH = 8;
  localparam int MAXH = 200;
  localparam int CD   = 20;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  emergency_request_conditioner_if bus ();

  emergency_request_conditioner dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] exp_q[$];
  logic [4:0] exp_v;

  // ---------------- reference model ----------------
  // holder: 0 none, 1 main granted, 2 side granted, 3 cooldown
  logic m_deb_m, m_deb_s, m_arm_m, m_arm_s, m_to, m_last_main;
  int   m_since_m, m_since_s, m_holder, m_held;
  logic hist_m[$];
  logic hist_s[$];

  function automatic bit all_differ(input logic q[$], input logic lvl);
    for (int j = 0; j < DEB; j++) if (q[j] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_deb_m = 0; m_deb_s = 0; m_arm_m = 1; m_arm_s = 1; m_to = 0;
    m_last_main = 1; m_since_m = DEB + 1; m_since_s = DEB + 1;
    m_holder = 0; m_held = 0;
    hist_m.delete(); hist_s.delete();
    for (int j = 0; j < DEB + 2; j++) begin
      hist_m.push_back(1'b0);
      hist_s.push_back(1'b0);
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    logic old_m, old_s, new_m, new_s, to_m, to_s, pick_s;
    old_m = m_deb_m; old_s = m_deb_s;
    new_m = old_m;   new_s = old_s;
    // debounce: window of raw samples taken DEB+2 .. 3 edges ago
    if (m_since_m < 100000) m_since_m++;
    if (m_since_s < 100000) m_since_s++;
    if (m_since_m >= DEB + 1 && all_differ(hist_m, old_m)) begin new_m = ~old_m; m_since_m = 0; end
    if (m_since_s >= DEB + 1 && all_differ(hist_s, old_s)) begin new_s = ~old_s; m_since_s = 0; end
    hist_m.push_back(bus.Main_Sensor_raw); void'(hist_m.pop_front());
    hist_s.push_back(bus.Side_Sensor_raw); void'(hist_s.pop_front());
    // arbitration on pre-edge debounced levels
    to_m = 0; to_s = 0;
    case (m_holder)
      0: begin
`ifdef ROUND_ROBIN_EN
        pick_s = (old_s && m_arm_s) && (!(old_m && m_arm_m) || m_last_main);
`else
        pick_s = old_s && m_arm_s;
`endif
        if (pick_s) begin m_holder = 2; m_held = 0; m_last_main = 0; end
        else if (old_m && m_arm_m) begin m_holder = 1; m_held = 0; m_last_main = 1; end
      end
      1: begin
        m_held++;
        if (m_held >= MINH && !old_m) m_holder = 0;
        else if (m_held == MAXH) begin m_holder = 3; m_held = 0; to_m = 1; end
      end
      2: begin
        m_held++;
        if (m_held >= MINH && !old_s) m_holder = 0;
        else if (m_held == MAXH) begin m_holder = 3; m_held = 0; to_s = 1; end
      end
      default: begin
        m_held++;
        if (m_held == CD) m_holder = 0;
      end
    endcase
    if (to_m) m_arm_m = 0; else if (!old_m) m_arm_m = 1;
    if (to_s) m_arm_s = 0; else if (!old_s) m_arm_s = 1;
    m_to = to_m | to_s;
    m_deb_m = new_m; m_deb_s = new_s;
    exp_q.push_back({m_holder == 1, m_holder == 2,
                     m_deb_m && m_arm_m && (m_holder != 1),
                     m_deb_s && m_arm_s && (m_holder != 2), m_to});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clk or negedge Rst_n);
      if (!Rst_n) model_reset();
      else model_step();
    end
  end

  function automatic logic [4:0] obs();
    return {bus.Main_Special, bus.Side_Special, bus.Main_Pending,
            bus.Side_Pending, bus.Timeout_Flag};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic test_reset();
    bus.Main_Sensor_raw = 0; bus.Side_Sensor_raw = 0;
    Rst_n = 0;
    repeat (3) @(negedge Clk);
    n_checks++;
    if (obs() !== 5'b0) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs(), 5'b0); end
    n_checks++;
    if (bus.state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", bus.state_dbg, ST_IDLE); end
    Rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (exp_q.size() > 0) exp_v = exp_q.pop_front(); else exp_v = 'x;
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL reset_idle cyc %0d: got %b want %b", i, obs(), exp_v); end
    end
  endtask

  task automatic test_clean_main_pulse();
    int rise_i = -1, high_cnt = 0, side_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (exp_q.size() > 0) exp_v = exp_q.pop_front(); else exp_v = 'x;
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL clean_main cyc %0d: got %b want %b", i, obs(), exp_v); end
      if (bus.Main_Special && rise_i < 0) rise_i = i;
      if (bus.Main_Special) high_cnt++;
      if (bus.Side_Special) side_cnt++;
      bus.Main_Sensor_raw = (i < 30);
    end
    // observation i follows edge i-1 counted from the first sample
    n_checks++;
    if (rise_i - 1 !== DEB + 3) begin n_fail++; $display("FAIL clean_main_latency: got %0d want %0d", rise_i - 1, DEB + 3); end
    n_checks++;
    if (high_cnt !== 30) begin n_fail++; $display("FAIL clean_main_width: got %0d want %0d", high_cnt, 30); end
    n_checks++;
    if (side_cnt !== 0) begin n_fail++; $display("FAIL clean_main_side: got %0d want %0d", side_cnt, 0); end
  endtask

  task automatic test_bounce_rejection();
    int bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (exp_q.size() > 0) exp_v = exp_q.pop_front(); else exp_v = 'x;
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL bounce cyc %0d: got %b want %b", i, obs(), exp_v); end
      if (bus.Side_Special || bus.Side_Pending) bad++;
      bus.Side_Sensor_raw = (i < 40) ? logic'((i / 2) % 2) : 1'b0;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL bounce_side_active: got %0d want %0d", bad, 0); end
  endtask

  task automatic test_min_hold();
    int high_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (exp_q.size() > 0) exp_v = exp_q.pop_front(); else exp_v = 'x;
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL min_hold cyc %0d: got %b want %b", i, obs(), exp_v); end
      if (bus.Main_Special) high_cnt++;
      bus.Main_Sensor_raw = (i < 5);
    end
    n_checks++;
    if (high_cnt !== MINH) begin n_fail++; $display("FAIL min_hold_width: got %0d want %0d", high_cnt, MINH); end
  endtask

  task automatic test_simultaneous();
    int first_grant, pend_cnt;
    for (int ev = 0; ev < 2; ev++) begin
      first_grant = 0; pend_cnt = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge Clk);
        if (exp_q.size() > 0) exp_v = exp_q.pop_front(); else exp_v = 'x;
        n_checks++;
        if (obs() !== exp_v) begin n_fail++; $display("FAIL simultaneous ev %0d cyc %0d: got %b want %b", ev, i, obs(), exp_v); end
        if (first_grant == 0 && bus.Side_Special) first_grant = 2;
        if (first_grant == 0 && bus.Main_Special) first_grant = 1;
        if ((bus.Side_Special && bus.Main_Pending) || (bus.Main_Special && bus.Side_Pending)) pend_cnt++;
        bus.Main_Sensor_raw = (i < 20);
        bus.Side_Sensor_raw = (i < 20);
      end
`ifdef ROUND_ROBIN_EN
      n_checks++;
      if (first_grant !== ((ev == 0) ? 2 : 1)) begin n_fail++; $display("FAIL simultaneous_winner ev %0d: got %0d want %0d", ev, first_grant, (ev == 0) ? 2 : 1); end
`else
      n_checks++;
      if (first_grant !== 2) begin n_fail++; $display("FAIL simultaneous_winner ev %0d: got %0d want %0d", ev, first_grant, 2); end
`endif
      n_checks++;
      if (pend_cnt == 0) begin n_fail++; $display("FAIL simultaneous_pending ev %0d: got %0d want >0", ev, pend_cnt); end
    end
  endtask

  task automatic test_queueing();
    int side_last = -1, main_rise = -1, pend_cnt = 0, both = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge Clk);
      if (exp_q.size() > 0) exp_v = exp_q.pop_front(); else exp_v = 'x;
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL queueing cyc %0d: got %b want %b", i, obs(), exp_v); end
      if (bus.Side_Special) side_last = i;
      if (bus.Side_Special && bus.Main_Pending) pend_cnt++;
      if (bus.Main_Special && main_rise < 0) main_rise = i;
      if (bus.Main_Special && bus.Side_Special) both++;
      bus.Side_Sensor_raw = (i < 20);
      bus.Main_Sensor_raw = (i < 40);
    end
    n_checks++;
    if (main_rise - side_last !== 2) begin n_fail++; $display("FAIL queueing_gap: got %0d want %0d", main_rise - side_last, 2); end
    n_checks++;
    if (pend_cnt !== 20) begin n_fail++; $display("FAIL queueing_pending: got %0d want %0d", pend_cnt, 20); end
    n_checks++;
    if (both !== 0) begin n_fail++; $display("FAIL queueing_exclusive: got %0d want %0d", both, 0); end
  endtask

  task automatic test_stuck_sensor();
    int side_cnt = 0, side_last = -1, side_rises = 0, to_cnt = 0, main_rise = -1;
    logic side_prev = 0;
    for (int i = 0; i < 520; i++) begin
      @(negedge Clk);
      if (exp_q.size() > 0) exp_v = exp_q.pop_front(); else exp_v = 'x;
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL stuck cyc %0d: got %b want %b", i, obs(), exp_v); end
      if (bus.Side_Special) begin side_cnt++; side_last = i; end
      if (bus.Side_Special && !side_prev) side_rises++;
      side_prev = bus.Side_Special;
      if (bus.Timeout_Flag) to_cnt++;
      if (bus.Main_Special && main_rise < 0) main_rise = i;
      bus.Side_Sensor_raw = (i < 400);
      bus.Main_Sensor_raw = (i >= 180 && i < 260);
    end
    n_checks++;
    if (side_cnt !== MAXH) begin n_fail++; $display("FAIL stuck_width: got %0d want %0d", side_cnt, MAXH); end
    n_checks++;
    if (to_cnt !== 1) begin n_fail++; $display("FAIL stuck_timeout_pulses: got %0d want %0d", to_cnt, 1); end
    n_checks++;
    if (side_rises !== 1) begin n_fail++; $display("FAIL stuck_regrant: got %0d want %0d", side_rises, 1); end
    n_checks++;
    if (main_rise - side_last !== CD + 2) begin n_fail++; $display("FAIL stuck_main_after_cooldown: got %0d want %0d", main_rise - side_last, CD + 2); end
  endtask

  task automatic test_reset_mid_grant();
    int rise_i = -1;
    bus.Main_Sensor_raw = 1;
    for (int i = 0; i < 20 && !bus.Main_Special; i++) begin
      @(negedge Clk);
      if (exp_q.size() > 0) exp_v = exp_q.pop_front(); else exp_v = 'x;
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL reset_mid_pre cyc %0d: got %b want %b", i, obs(), exp_v); end
    end
    n_checks++;
    if (bus.Main_Special !== 1'b1) begin n_fail++; $display("FAIL reset_mid_grant_seen: got %b want %b", bus.Main_Special, 1'b1); end
    repeat (3) begin @(negedge Clk); if (exp_q.size() > 0) void'(exp_q.pop_front()); end
    #2 Rst_n = 0;
    #1;
    n_checks++;
    if (obs() !== 5'b0) begin n_fail++; $display("FAIL reset_mid_async: got %b want %b", obs(), 5'b0); end
    @(negedge Clk);
    Rst_n = 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (exp_q.size() > 0) exp_v = exp_q.pop_front(); else exp_v = 'x;
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL reset_mid_post cyc %0d: got %b want %b", i, obs(), exp_v); end
      if (bus.Main_Special && rise_i < 0) rise_i = i;
      if (i == 15) bus.Main_Sensor_raw = 0;
    end
    n_checks++;
    if (rise_i - 1 !== DEB + 3) begin n_fail++; $display("FAIL reset_mid_regrant: got %0d want %0d", rise_i - 1, DEB + 3); end
  endtask

  task automatic test_random();
    int seg_m = 0, seg_s = 0;
    logic lv_m = 0, lv_s = 0;
    for (int i = 0; i < 1800; i++) begin
      @(negedge Clk);
      if (exp_q.size() > 0) exp_v = exp_q.pop_front(); else exp_v = 'x;
      n_checks++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL random cyc %0d: got %b want %b", i, obs(), exp_v); end
      if (i >= 1750) begin
        bus.Main_Sensor_raw = 0; bus.Side_Sensor_raw = 0;
      end else begin
        if (seg_m == 0) begin
          lv_m = 1'($urandom_range(0, 1));
          seg_m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(150, 260)) : int'($urandom_range(1, 40));
        end
        if (seg_s == 0) begin
          lv_s = 1'($urandom_range(0, 1));
          seg_s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(150, 260)) : int'($urandom_range(1, 40));
        end
        seg_m--; seg_s--;
        bus.Main_Sensor_raw = ($urandom_range(0, 15) == 0) ? ~lv_m : lv_m;
        bus.Side_Sensor_raw = ($urandom_range(0, 15) == 0) ? ~lv_s : lv_s;
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_clean_main_pulse();
    test_bounce_rejection();
    test_min_hold();
    test_simultaneous();
    test_queueing();
    test_stuck_sensor();
    test_reset_mid_grant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
